// File: rtl/line_buffer_vector.sv
// Vertical pixel-column line buffer: VECTOR_SIZE-1 chained line memories.
// Optional prime gating via `define LINE_BUFFER_PRIME_GATE_EN.
module line_buffer_vector #(
    parameter int IMAGE_WIDTH = 1280,
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 3
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [DATA_WIDTH-1:0]           s_pixel_data,
    input  logic                            s_pixel_valid,
    input  logic                            s_pixel_sof,
    output logic [VECTOR_SIZE*DATA_WIDTH-1:0] m_vector_data,
    output logic                            m_vector_valid
);

    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int NM = VECTOR_SIZE - 1;
    localparam int VW = VECTOR_SIZE * DATA_WIDTH;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [CW-1:0]         cur_col;
    logic [RW-1:0]         cur_row;
    logic [CW-1:0]         next_col;
    logic [RW-1:0]         next_row;
    logic                  wrap;
    logic                  emit;
    logic [VW-1:0]         vec;
    logic [DATA_WIDTH-1:0] tap [NM];
    logic [DATA_WIDTH-1:0] line_mem [NM][IMAGE_WIDTH];

    // A start-of-frame pixel always lands at column 0, row 0.
    assign cur_col = s_pixel_sof ? '0 : col;
    assign cur_row = s_pixel_sof ? '0 : row;
    assign wrap    = (cur_col == CW'(IMAGE_WIDTH - 1));

`ifdef LINE_BUFFER_PRIME_GATE_EN
    assign emit = s_pixel_valid &&
                  (cur_row == RW'(VECTOR_SIZE - 1));
`else
    assign emit = s_pixel_valid;
`endif

    // Counter advance: column wraps, row saturates once all lines primed.
    always_comb begin
        next_col = cur_col + CW'(1);
        next_row = cur_row;
        if (wrap) begin
            next_col = '0;
            if (cur_row != RW'(VECTOR_SIZE - 1))
                next_row = cur_row + RW'(1);
        end
    end

    // Read every line memory at the current column.
    always_comb begin
        for (int k = 0; k < NM; k++)
            tap[k] = line_mem[k][cur_col];
    end

    // Pack the column; lines not yet written this frame read as zero.
    always_comb begin
        vec = '0;
        vec[DATA_WIDTH-1:0] = s_pixel_data;
        for (int k = 1; k < VECTOR_SIZE; k++) begin
            if (RW'(k) <= cur_row)
                vec[k*DATA_WIDTH +: DATA_WIDTH] = tap[k-1];
        end
    end

    // Shift the new pixel down the memory chain (read-before-write).
    always_ff @(posedge clk) begin
        if (s_pixel_valid) begin
            line_mem[0][cur_col] <= s_pixel_data;
            for (int k = 1; k < NM; k++)
                line_mem[k][cur_col] <= tap[k-1];
        end
    end

    // Position counters, held while no pixel is offered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (s_pixel_valid) begin
            col <= next_col;
            row <= next_row;
        end
    end

    // Output register; data only moves when a vector is emitted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_vector_valid <= 1'b0;
            m_vector_data  <= '0;
        end else begin
            m_vector_valid <= emit;
            if (emit)
                m_vector_data <= vec;
        end
    end

endmodule

// File: tb/tb_line_buffer_vector.sv
// Scoreboard bench for line_buffer_vector (W=4, V=3, D=8).
// Honours LINE_BUFFER_PRIME_GATE_EN for expected-valid selection.
module tb_line_buffer_vector;

`ifdef LINE_BUFFER_PRIME_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic [7:0]  s_pixel_data;
    logic        s_pixel_valid;
    logic        s_pixel_sof;
    logic [23:0] m_vector_data;
    logic        m_vector_valid;

    typedef struct {
        logic [23:0] d;
        int          cyc;
    } exp_t;

    exp_t        sbq [$];
    logic [7:0]  frame [0:7][0:3];
    logic [23:0] last_exp;
    int          cyc;
    int          tests;
    int          fails;

    line_buffer_vector #(
        .IMAGE_WIDTH(4),
        .DATA_WIDTH (8),
        .VECTOR_SIZE(3)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_pixel_data  (s_pixel_data),
        .s_pixel_valid (s_pixel_valid),
        .s_pixel_sof   (s_pixel_sof),
        .m_vector_data (m_vector_data),
        .m_vector_valid(m_vector_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] expv(input int line, input int c);
        logic [23:0] v;
        int          r;
        v = '0;
        r = (line > 2) ? 2 : line;
        for (int k = 0; k <= r; k++)
            v[k*8 +: 8] = frame[line-k][c];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sof,
                        input int line, input int c);
        exp_t e;
        @(negedge clk);
        s_pixel_valid = 1'b1;
        s_pixel_data  = d;
        s_pixel_sof   = sof;
        frame[line][c] = d;
        if (!GATE || line >= 2) begin
            e.d   = expv(line, c);
            e.cyc = cyc + 1;
            sbq.push_back(e);
            last_exp = e.d;
        end
    endtask

    task automatic send_row(input logic [7:0] base, input int line,
                            input bit sof);
        for (int c = 0; c < 4; c++)
            send(base + 8'(c), sof && (c == 0), line, c);
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_pixel_valid = 1'b0;
            s_pixel_sof   = 1'b0;
            s_pixel_data  = 8'($urandom);
            @(posedge clk);
            #2;
            chk("idle_valid", 32'(m_vector_valid), 32'd0);
            chk("idle_hold", 32'(m_vector_data), 32'(last_exp));
        end
    endtask

    // Monitor: every presented vector is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (m_vector_valid === 1'b1) begin
                tests++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_vector: got %h at cycle %0d, expected none",
                             m_vector_data, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (m_vector_data !== e.d || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL vector: got %h at cycle %0d, expected %h at cycle %0d",
                                 m_vector_data, cyc, e.d, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        cyc           = 0;
        tests         = 0;
        fails         = 0;
        last_exp      = '0;
        resetn        = 1'b0;
        s_pixel_valid = 1'b0;
        s_pixel_data  = '0;
        s_pixel_sof   = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_pixel_valid = 1'($urandom);
            s_pixel_sof   = 1'($urandom);
            s_pixel_data  = 8'($urandom);
            @(posedge clk);
            #2;
            chk("reset_valid", 32'(m_vector_valid), 32'd0);
            chk("reset_data", 32'(m_vector_data), 32'd0);
        end
        @(negedge clk);
        resetn        = 1'b1;
        s_pixel_valid = 1'b0;
        s_pixel_sof   = 1'b0;

        send_row(8'h00, 0, 1'b1);
        send_row(8'h10, 1, 1'b0);
        send(8'h20, 1'b0, 2, 0);
        send(8'h21, 1'b0, 2, 1);
        idle_chk(3);
        send(8'h22, 1'b0, 2, 2);
        send(8'h23, 1'b0, 2, 3);
        send_row(8'h30, 3, 1'b0);
        send(8'h40, 1'b0, 4, 0);
        send(8'h41, 1'b0, 4, 1);

        send(8'h42, 1'b1, 0, 0);
        send(8'h81, 1'b0, 0, 1);
        send(8'h82, 1'b0, 0, 2);
        send(8'h83, 1'b0, 0, 3);
        send_row(8'h90, 1, 1'b0);
        send_row(8'hA0, 2, 1'b0);

        send_row(8'hB0, 0, 1'b1);
        send_row(8'hC0, 1, 1'b0);
        send(8'hD0, 1'b0, 2, 0);
        send(8'hD1, 1'b0, 2, 1);
        @(negedge clk);
        s_pixel_valid = 1'b0;
        resetn        = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_vector_valid), 32'd0);
        chk("async_rst_data", 32'(m_vector_data), 32'd0);
        repeat (2) @(negedge clk);
        resetn   = 1'b1;
        last_exp = '0;

        send_row(8'hE0, 0, 1'b0);
        send_row(8'hF0, 1, 1'b0);
        send_row(8'h60, 2, 1'b0);
        @(negedge clk);
        s_pixel_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
